// File: rtl/factorial_seq_ctrl_if.sv
// Handshake bundle for factorial_seq_ctrl.
// The requester (master) drives start/a/ack; the sequencer (slave) returns
// busy/done/z. The ovf signal exists only when FACTORIAL_OVF_EN is defined.
interface factorial_seq_ctrl_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 14
);
    logic             start;
    logic [IN_W-1:0]  a;
    logic             busy;
    logic             done;
    logic             ack;
    logic [OUT_W-1:0] z;
`ifdef FACTORIAL_OVF_EN
    logic             ovf;

    modport master (output start, a, ack, input busy, done, z, ovf);
    modport slave  (input start, a, ack, output busy, done, z, ovf);
`else
    modport master (output start, a, ack, input busy, done, z);
    modport slave  (input start, a, ack, output busy, done, z);
`endif
endinterface

// File: rtl/factorial_seq_ctrl.sv
// factorial_seq_ctrl: iterative factorial sequencer, one multiply per clock.
// Result is a! truncated to OUT_W bits; 0! and 1! both give 1.
// Optional macro FACTORIAL_OVF_EN adds a sticky overflow flag (bus.ovf).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; operand captured on the accepting edge
//   S_CALC | acc *= cnt, cnt -= 1 while cnt > 1; then latch z
//   S_DONE | done held high, z stable, until ack
module factorial_seq_ctrl #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    factorial_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int              PROD_W  = OUT_W + IN_W;
    localparam logic [IN_W-1:0] CNT_ONE = IN_W'(1);
    localparam logic [OUT_W-1:0] ACC_ONE = OUT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_cnt;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_z;
    logic              w_cnt_gt1;
    logic [PROD_W-1:0] w_acc_ext;
    logic [PROD_W-1:0] w_cnt_ext;
    logic [OUT_W-1:0]  w_acc_nxt;

    assign w_cnt_gt1 = (r_cnt > CNT_ONE);
    assign w_acc_ext = {{IN_W{1'b0}}, r_acc};
    assign w_cnt_ext = {{OUT_W{1'b0}}, r_cnt};

    // Product is formed at full width; only the low OUT_W bits feed back.
`ifdef FACTORIAL_OVF_EN
    logic [PROD_W-1:0] w_prod;
    logic              w_prod_ovf;
    logic              r_ovf;

    assign w_prod     = w_acc_ext * w_cnt_ext;
    assign w_acc_nxt  = w_prod[OUT_W-1:0];
    assign w_prod_ovf = |w_prod[PROD_W-1:OUT_W];
    assign bus.ovf    = r_ovf;
`else
    assign w_acc_nxt = OUT_W'(w_acc_ext * w_cnt_ext);
`endif

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.z    = r_z;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; start is only looked at in IDLE, ack only in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
            S_CALC:  if (!w_cnt_gt1) w_state_nxt = S_DONE;
            S_DONE:  if (bus.ack)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, multiply-accumulate, result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= ACC_ONE;
            r_z   <= '0;
`ifdef FACTORIAL_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt <= bus.a;
                        r_acc <= ACC_ONE;
`ifdef FACTORIAL_OVF_EN
                        r_ovf <= 1'b0;
`endif
                    end
                end
                S_CALC: begin
                    if (w_cnt_gt1) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt - CNT_ONE;
`ifdef FACTORIAL_OVF_EN
                        r_ovf <= r_ovf | w_prod_ovf;
`endif
                    end else begin
                        r_z <= r_acc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Testbench for factorial_seq_ctrl: directed vector table, hand-written
// corner sequences and random operands against a plain-arithmetic model.
module tb_factorial_seq_ctrl;
`ifdef FACTORIAL_OVF_EN
    localparam int IN_W = 4;
`else
    localparam int IN_W = 3;
`endif
    localparam int OUT_W = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    factorial_seq_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    factorial_seq_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int     a;
        longint z;
        int     lat;
        logic   ovf;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint fact_full(input int n);
        longint f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    function automatic logic cur_ovf();
`ifdef FACTORIAL_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request, count edges from the accepting edge until done.
    task automatic run_op(input int av, output int lat, output logic [OUT_W-1:0] zv,
                          output logic ov, output logic zmoved, output logic busy1);
        logic [OUT_W-1:0] zprev;
        @(negedge clk);
        zprev     = bus.z;
        bus.a     = IN_W'(av);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = IN_W'($urandom);
        busy1     = bus.busy;
        lat       = 0;
        zmoved    = 1'b0;
        while (!bus.done && lat < 64) begin
            if (bus.z !== zprev) zmoved = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        zv = bus.z;
        ov = cur_ovf();
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               lat;
        logic [OUT_W-1:0] zv;
        logic             ov, zm, b1, seen;
        longint           fz;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.ack   = 1'b0;

        vt.push_back('{0, 1, 1, 1'b0});
        vt.push_back('{1, 1, 1, 1'b0});
        vt.push_back('{2, 2, 2, 1'b0});
        vt.push_back('{3, 6, 3, 1'b0});
        vt.push_back('{4, 24, 4, 1'b0});
        vt.push_back('{5, 120, 5, 1'b0});
        vt.push_back('{6, 720, 6, 1'b0});
`ifdef FACTORIAL_OVF_EN
        vt.push_back('{8, 7552, 8, 1'b1});
`endif
        vt.push_back('{7, 5040, 7, 1'b0});

        // reset state
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_z", bus.z, 0);
        chk("rst_ovf", cur_ovf(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // a=5 basic flow, done held until ack
        run_op(5, lat, zv, ov, zm, b1);
        chk("a5_busy_next", b1, 1);
        chk("a5_lat", lat, 5);
        chk("a5_z", zv, 120);
        repeat (3) @(negedge clk);
        chk("a5_done_hold", bus.done, 1);
        chk("a5_z_hold", bus.z, 120);
        do_ack();
        chk("a5_idle_done", bus.done, 0);
        chk("a5_idle_busy", bus.busy, 0);

        // vector table
        foreach (vt[i]) begin
            run_op(vt[i].a, lat, zv, ov, zm, b1);
            chk($sformatf("tbl_a%0d_lat", vt[i].a), lat, vt[i].lat);
            chk($sformatf("tbl_a%0d_z", vt[i].a), zv, vt[i].z);
            chk($sformatf("tbl_a%0d_zstable", vt[i].a), zm, 0);
`ifdef FACTORIAL_OVF_EN
            chk($sformatf("tbl_a%0d_ovf", vt[i].a), ov, vt[i].ovf);
`endif
            do_ack();
        end

        // a=7 with start held high and a=3 during CALC/DONE
        @(negedge clk);
        bus.a = IN_W'(7);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = IN_W'(3);
        lat = 0;
        while (!bus.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_lat", lat, 7);
        chk("hold_z", bus.z, 5040);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done_stays", bus.done, 1);
        chk("hold_z_stays", bus.z, 5040);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("hold_idle", bus.busy, 0);

        // start and ack together in DONE
        run_op(3, lat, zv, ov, zm, b1);
        chk("sa_z3", zv, 6);
        @(negedge clk);
        bus.a = IN_W'(2);
        bus.start = 1'b1;
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        chk("sa_idle_busy", bus.busy, 0);
        chk("sa_idle_done", bus.done, 0);
        @(posedge clk);
        #1;
        chk("sa_no_new_op", bus.busy, 0);
        run_op(2, lat, zv, ov, zm, b1);
        chk("sa_a2_lat", lat, 2);
        chk("sa_a2_z", zv, 2);
        do_ack();

        // ack in IDLE and mid-CALC has no effect
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("ack_idle_busy", bus.busy, 0);
        @(negedge clk);
        bus.a = IN_W'(6);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("ack_calc_busy", bus.busy, 1);
        while (!bus.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ack_calc_lat", lat, 6);
        chk("ack_calc_z", bus.z, 720);
        do_ack();

        // asynchronous reset mid-CALC
        @(negedge clk);
        bus.a = IN_W'(6);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_z", bus.z, 0);
        chk("arst_ovf", cur_ovf(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("arst_no_done", seen, 0);
        chk("arst_z_kept", bus.z, 0);
        run_op(4, lat, zv, ov, zm, b1);
        chk("arst_a4_lat", lat, 4);
        chk("arst_a4_z", zv, 24);
        do_ack();

        // random operands against the arithmetic model
        repeat (25) begin
            int n;
            n  = int'($urandom_range(0, (1 << IN_W) - 1));
            fz = fact_full(n);
            run_op(n, lat, zv, ov, zm, b1);
            chk($sformatf("rnd_a%0d_lat", n), lat, (n < 1) ? 1 : n);
            chk($sformatf("rnd_a%0d_z", n), zv, fz % (longint'(1) << OUT_W));
            chk($sformatf("rnd_a%0d_zstable", n), zm, 0);
`ifdef FACTORIAL_OVF_EN
            chk($sformatf("rnd_a%0d_ovf", n), ov, (fz >= (longint'(1) << OUT_W)));
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_ack();
            chk($sformatf("rnd_a%0d_idle", n), bus.busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/factorial_seq_ctrl.md
FACTORIAL_SEQ_CTRL -- requirements
Module: factorial_seq_ctrl

Interface
REQ-001 Parameter IN_W, default 3: operand width in bits.
REQ-002 Parameter OUT_W, default 14: result width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to compute the factorial of a; sampled only in IDLE.
REQ-006 Port a  input  IN_W  operand; captured on the accepting edge, ignored otherwise.
REQ-007 Port busy  output  1  high whenever state is not IDLE.
REQ-008 Port done  output  1  result valid; held high until acknowledged.
REQ-009 Port ack  input  1  result consumed; meaningful only while done is high.
REQ-010 Port z  output  OUT_W  result; stable while done is high.
REQ-011 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: on start=1 the block SHALL go to CALC and load cnt<=a and acc<=1 in the same edge; with start=0 it SHALL stay in IDLE.
REQ-014 CALC with cnt>1: the block SHALL set acc<=acc*cnt truncated to OUT_W bits and cnt<=cnt-1.
REQ-015 CALC with cnt<=1: the block SHALL set z<=acc and go to DONE.
REQ-016 DONE: the block SHALL drive done=1; on ack=1 it SHALL return to IDLE with done deasserted on the following cycle.
REQ-017 The multiply SHALL form a full OUT_W+IN_W product internally before truncation.
REQ-018 Latency: done SHALL rise exactly max(a,1) clock edges after the accepting edge, i.e. 1 edge for a=0 or a=1 and 7 edges for a=7.
REQ-019 The result SHALL be a=0 -> z=1 and a=1 -> z=1; otherwise z = a! mod 2^OUT_W.
REQ-020 Whenever busy=1, start SHALL be ignored, including start and ack asserted together in DONE; the new request must be reissued in IDLE.
REQ-021 ack outside DONE SHALL have no effect.
REQ-022 z SHALL hold its last value in IDLE and CALC and SHALL change only on the CALC->DONE edge.
REQ-023 busy SHALL be a decode of the state register (registered timing), not a function of start.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, cnt=0, acc=1, z=0, done=0 and busy=0, regardless of clock.
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation, with no done pulse and no z update after release.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Configuration
REQ-027 Macro FACTORIAL_OVF_EN SHALL control overflow detection.
REQ-028 With FACTORIAL_OVF_EN defined, the block SHALL add output ovf (1 bit).
- ovf is cleared on the accepting edge.
- ovf is set sticky when any CALC product has nonzero bits above OUT_W-1.
- ovf is valid with done and reset to 0.
REQ-029 Without FACTORIAL_OVF_EN, the ovf port and its logic SHALL be absent, and truncation is silent.

Verification
REQ-030 Reset then a=5, start for 1 cycle -> busy high next cycle; done after 5 edges; z=120; done holds until ack; IDLE one cycle after ack.
REQ-031 a=0, then a=1 -> each gives done 1 edge after accept with z=1.
REQ-032 a=7 -> z=5040 after 7 edges; start=1 with a=3 held throughout CALC and DONE -> no restart and z stays 5040 until ack.
REQ-033 In DONE assert start and ack together with a=2 -> return to IDLE with no new op; start again -> z=2 after 2 edges.
REQ-034 Assert rst_n=0 mid-CALC for a=6 (asynchronously, between edges) -> outputs reset immediately; no done follows; next a=4 -> z=24.
REQ-035 FACTORIAL_OVF_EN, IN_W=4, OUT_W=14: a=8 -> ovf=1 with z = 40320 mod 16384 = 7552; a=7 -> ovf=0 with z=5040.
